// File: rtl/sha256_pkg.sv
// sha256_pkg: shared state type, block constants and last-word padding helper for the SHA-256 message padder
package sha256_pkg;
  typedef enum logic [1:0] {FILL, PAD, LEN, ISSUE} state_t;
  localparam logic [4:0] BLOCK_WORDS = 5'd16;
  localparam logic [4:0] LEN_WORD_IDX = 5'd14;
  localparam logic [7:0] PAD_BYTE = 8'h80;
  function automatic logic [31:0] pad_last_word(input logic [31:0] data, input logic [2:0] nbytes);
    logic [2:0] n;
    logic [5:0] sh;
    n = nbytes > 3'd4 ? 3'd4 : nbytes;
    sh = {n, 3'b000};
    return n == 3'd4 ? data : (data & ~(32'hffff_ffff >> sh)) | ({PAD_BYTE, 24'h0} >> sh);
  endfunction
endpackage

// File: rtl/sha256_msg_padder.sv
// sha256_msg_padder: FIPS 180-4 message padder feeding 512-bit blocks to the SHA-256 core; SHA256_PAD_BLKCNT_EN adds blk_count
module sha256_msg_padder
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  in_data,
  input  logic         in_valid,
  input  logic         in_last,
  input  logic [2:0]   in_bytes,
  output logic         in_ready,
  input  logic         core_ready,
  output logic         next,
  output logic [511:0] block,
  output logic         first_block,
`ifdef SHA256_PAD_BLKCNT_EN
  output logic [31:0]  blk_count,
`endif
  output logic         msg_done
);
  state_t state, state_n, ret, ret_n;
  logic [31:0] mem [BLOCK_WORDS];
  logic [4:0] widx, widx_n;
  logic [63:0] bitlen, bitlen_n;
  logic pad_pending, pad_pending_n, fin, fin_n, first, first_n;
  logic we;
  logic [31:0] wdata;
  logic [2:0] nb;
  always_comb begin
    nb = in_bytes > 3'd4 ? 3'd4 : in_bytes;
    in_ready = state == FILL && !rst;
    next = state == ISSUE && core_ready && !rst;
    first_block = next && first;
    msg_done = next && fin;
    state_n = state;
    ret_n = ret;
    widx_n = widx;
    bitlen_n = bitlen;
    pad_pending_n = pad_pending;
    fin_n = fin;
    first_n = first;
    we = 1'b0;
    wdata = '0;
    case (state)
      FILL: if (in_valid) begin
        we = 1'b1;
        widx_n = widx + 5'd1;
        wdata = in_last ? pad_last_word(in_data, in_bytes) : in_data;
        bitlen_n = bitlen + (in_last ? {58'b0, nb, 3'b000} : 64'd32);
        pad_pending_n = in_last && nb == 3'd4;
        if (in_last) state_n = PAD;
        else if (widx_n == BLOCK_WORDS) begin
          ret_n = FILL;
          state_n = ISSUE;
        end
      end
      PAD: begin
        // a full buffer (widx 16) must be issued before the pending 0x80 word can land
        we = widx != BLOCK_WORDS && (pad_pending || widx != LEN_WORD_IDX);
        wdata = pad_pending ? {PAD_BYTE, 24'h0} : '0;
        if (we) begin
          widx_n = widx + 5'd1;
          pad_pending_n = 1'b0;
        end
        state_n = widx_n == LEN_WORD_IDX ? LEN : widx_n == BLOCK_WORDS ? ISSUE : PAD;
        ret_n = widx_n == BLOCK_WORDS ? PAD : ret;
      end
      LEN: begin
        we = 1'b1;
        wdata = widx == LEN_WORD_IDX ? bitlen[63:32] : bitlen[31:0];
        widx_n = widx + 5'd1;
        if (widx != LEN_WORD_IDX) begin
          fin_n = 1'b1;
          ret_n = FILL;
          state_n = ISSUE;
        end
      end
      ISSUE: if (core_ready) begin
        widx_n = '0;
        first_n = fin;
        state_n = ret;
        fin_n = 1'b0;
        bitlen_n = fin ? '0 : bitlen;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL;
      ret <= FILL;
      widx <= '0;
      bitlen <= '0;
      pad_pending <= 1'b0;
      fin <= 1'b0;
      first <= 1'b1;
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else begin
      state <= state_n;
      ret <= ret_n;
      widx <= widx_n;
      bitlen <= bitlen_n;
      pad_pending <= pad_pending_n;
      fin <= fin_n;
      first <= first_n;
      if (we) mem[widx[3:0]] <= wdata;
    end
  end
  for (genvar i = 0; i < 16; i++) begin : g_blk
    assign block[511-32*i -: 32] = mem[i];
  end
`ifdef SHA256_PAD_BLKCNT_EN
  always_ff @(posedge clk) begin
    if (rst) blk_count <= '0;
    else if (next) blk_count <= blk_count + 32'd1;
  end
`endif
endmodule

// File: tb/tb_sha256_msg_padder.sv
// tb_sha256_msg_padder: directed self-checking bench for the SHA-256 message padder
module tb_sha256_msg_padder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] in_data = '0;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic [2:0] in_bytes = '0;
  logic core_ready = 1'b1;
  logic in_ready, next, first_block, msg_done;
  logic [511:0] block;
`ifdef SHA256_PAD_BLKCNT_EN
  logic [31:0] blk_count;
`endif
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int n0;
  logic [511:0] blks[$];
  logic fbs[$];
  logic mds[$];
  int cycs[$];
  logic [511:0] exp_blk, exp2;
  sha256_msg_padder dut (
    .clk(clk),
    .rst(rst),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_last(in_last),
    .in_bytes(in_bytes),
    .in_ready(in_ready),
    .core_ready(core_ready),
    .next(next),
    .block(block),
    .first_block(first_block),
`ifdef SHA256_PAD_BLKCNT_EN
    .blk_count(blk_count),
`endif
    .msg_done(msg_done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (next === 1'b1) begin
      blks.push_back(block);
      fbs.push_back(first_block);
      mds.push_back(msg_done);
      cycs.push_back(cyc);
    end
  end
  function automatic logic [31:0] wd(input int i);
    return 32'h0f00_0000 + 32'(i) * 32'h0101_0101;
  endfunction
  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [31:0] d, input logic l, input logic [2:0] b);
    int t;
    logic acc;
    t = 0;
    in_data = d;
    in_last = l;
    in_bytes = b;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      t++;
    end while (acc !== 1'b1 && t < 200);
    acc_cyc = cyc;
    in_valid = 1'b0;
    in_last = 1'b0;
    if (acc !== 1'b1) chk("send_timeout", {511'b0, acc}, 512'd1);
  endtask
  task automatic wait_nexts(input int target, input int budget, input string tag);
    int t;
    t = 0;
    while (blks.size() < target && t < budget) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk(tag, blks.size(), target);
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    idle(2);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_next", next, 1'b0);
    chk("rst_block", block, '0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1'b1);
    chk("post_rst_first_block", first_block, 1'b0);
    chk("post_rst_msg_done", msg_done, 1'b0);
    idle(1);
    // "abc"
    n0 = blks.size();
    send(32'h6162_6300, 1'b1, 3'd3);
    wait_nexts(n0 + 1, 40, "abc_wait");
    chk("abc_latency", cycs[n0] - (acc_cyc - 1), 16);
    chk("abc_block", blks[n0], {32'h6162_6380, 448'h0, 32'h0000_0018});
    chk("abc_first", fbs[n0], 1'b1);
    chk("abc_done", mds[n0], 1'b1);
    idle(20);
    chk("abc_count", blks.size(), n0 + 1);
    chk("abc_in_ready", in_ready, 1'b1);
    // empty message
    n0 = blks.size();
    send(32'h0, 1'b1, 3'd0);
    wait_nexts(n0 + 1, 40, "empty_wait");
    chk("empty_block", blks[n0], {32'h8000_0000, 480'h0});
    chk("empty_first", fbs[n0], 1'b1);
    chk("empty_done", mds[n0], 1'b1);
    // 55 bytes
    n0 = blks.size();
    for (int i = 0; i < 13; i++) send(wd(i), 1'b0, 3'd0);
    send(wd(13), 1'b1, 3'd3);
    wait_nexts(n0 + 1, 40, "b55_wait");
    exp_blk = '0;
    for (int i = 0; i < 13; i++) exp_blk[511-32*i -: 32] = wd(i);
    exp_blk[95:64] = 32'h1c0d_0d80;
    exp_blk[31:0] = 32'h0000_01b8;
    chk("b55_block", blks[n0], exp_blk);
    chk("b55_first", fbs[n0], 1'b1);
    chk("b55_done", mds[n0], 1'b1);
    idle(20);
    chk("b55_count", blks.size(), n0 + 1);
    // 56 bytes: length does not fit, extra block
    n0 = blks.size();
    for (int i = 0; i < 14; i++) send(wd(i), i == 13, 3'd4);
    wait_nexts(n0 + 2, 60, "b56_wait");
    exp_blk = '0;
    for (int i = 0; i < 14; i++) exp_blk[511-32*i -: 32] = wd(i);
    exp_blk[63:32] = 32'h8000_0000;
    chk("b56_blk1", blks[n0], exp_blk);
    chk("b56_blk1_first", fbs[n0], 1'b1);
    chk("b56_blk1_done", mds[n0], 1'b0);
    chk("b56_blk2", blks[n0+1], {480'h0, 32'h0000_01c0});
    chk("b56_blk2_first", fbs[n0+1], 1'b0);
    chk("b56_blk2_done", mds[n0+1], 1'b1);
    // 64 bytes with core stalled after the first block
    n0 = blks.size();
    for (int i = 0; i < 16; i++) send(wd(i), i == 15, 3'd4);
    wait_nexts(n0 + 1, 20, "b64_wait1");
    core_ready = 1'b0;
    exp2 = {32'h8000_0000, 448'h0, 32'h0000_0200};
    idle(30);
    chk("b64_stall_count_a", blks.size(), n0 + 1);
    chk("b64_stall_in_ready_a", in_ready, 1'b0);
    chk("b64_stall_block_a", block, exp2);
    idle(40);
    chk("b64_stall_count_b", blks.size(), n0 + 1);
    chk("b64_stall_in_ready_b", in_ready, 1'b0);
    chk("b64_stall_block_b", block, exp2);
    core_ready = 1'b1;
    wait_nexts(n0 + 2, 10, "b64_wait2");
    exp_blk = '0;
    for (int i = 0; i < 16; i++) exp_blk[511-32*i -: 32] = wd(i);
    chk("b64_blk1", blks[n0], exp_blk);
    chk("b64_blk1_first", fbs[n0], 1'b1);
    chk("b64_blk1_done", mds[n0], 1'b0);
    chk("b64_blk2", blks[n0+1], exp2);
    chk("b64_blk2_first", fbs[n0+1], 1'b0);
    chk("b64_blk2_done", mds[n0+1], 1'b1);
    // reset mid-message, then "abc"
    for (int i = 0; i < 9; i++) send(wd(i), 1'b0, 3'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_next", next, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    n0 = blks.size();
    send(32'h6162_6300, 1'b1, 3'd3);
    wait_nexts(n0 + 1, 40, "midrst_wait");
    chk("midrst_block", blks[n0], {32'h6162_6380, 448'h0, 32'h0000_0018});
    chk("midrst_first", fbs[n0], 1'b1);
    chk("midrst_done", mds[n0], 1'b1);
    idle(20);
    chk("midrst_count", blks.size(), n0 + 1);
`ifdef SHA256_PAD_BLKCNT_EN
    chk("midrst_blk_count", blk_count, 32'd1);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sha256_msg_padder.md
# sha256_msg_padder

Upstream feeder for the SHA-256 round controller. Accepts a message as a stream of 32-bit big-endian words and assembles 512-bit blocks. Performs FIPS 180-4 padding: a 0x80 byte, zero fill, and a 64-bit bit length, adding an extra block when required. Issues each block to the core with a one-cycle `next` pulse, sent only while the core reports `core_ready`.

## Interface
- No parameters; block size (16 words), word width (32) and length field (64 bits) are fixed constants.
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- in_data  in  32  message word; first byte in bits 31:24
- in_valid  in  1  in_data valid
- in_last  in  1  word is final word of message
- in_bytes  in  3  valid bytes in final word, 0..4, left-justified; ignored unless in_last; values 5..7 treated as 4
- in_ready  out  1  padder accepts a word this cycle (in_valid && in_ready)
- core_ready  in  1  downstream core idle, can take a block
- next  out  1  one-cycle pulse; block is valid and the core latches it this cycle
- block  out  512  assembled block; word 0 in bits 511:480
- first_block  out  1  high with `next` for the first block of a message (core loads IV)
- msg_done  out  1  high with `next` for the final block of a message

## Operation
- States: FILL, PAD, LEN, ISSUE. Registers: 16x32 buffer, word index `widx` (0..16), 64-bit `bitlen`, flags `pad_pending`, `final`, `first`, return state `ret`.
- FILL: in_ready=1. On accept, write the word at widx and increment widx.
  - Non-last word: bitlen += 32. If widx becomes 16: ret=FILL, go to ISSUE.
  - Last word: bitlen += 8*in_bytes. For in_bytes < 4, write data bytes, then 0x80 in the next byte lane, then zeros. For in_bytes=4, write the full word and set pad_pending. in_bytes=0 writes 0x80000000, which covers the empty message. Go to PAD.
- PAD: one word per cycle.
  - First, if pad_pending, write 0x80000000 and clear the flag.
  - If widx ≤ 14, write zeros until widx=14, then go to LEN. If widx is already 14, go to LEN without writing.
  - If widx > 14, write zeros until widx=16, then ret=PAD and go to ISSUE. Resume at widx=0, zero-fill to 14, then go to LEN.
- LEN: write bitlen[63:32] at word 14, then bitlen[31:0] at word 15. Set final=1, ret=FILL, go to ISSUE.
- ISSUE: in_ready=0. Wait for core_ready=1; in that cycle assert next=1, first_block=first, msg_done=final.
  - Then clear first, reset widx=0 and go to ret.
  - If final: clear final, clear bitlen and set first=1 for the next message.
- The core latches `block` in the `next` cycle. The padder may overwrite the buffer from the following cycle, so the next block fills while the core runs rounds.
- Arithmetic: bitlen wraps modulo 2^64, with no error.

## Timing
- Reset values: in_ready=0 during the rst cycle, then 1 (FILL); next=0, first_block=0, msg_done=0, block=0. Internal: first=1, bitlen=0, widx=0.
- rst mid-message discards the partial block and bitlen. A `next` pulse is never issued in a cycle where rst=1.
- Throughput: one word per cycle in FILL.
- Full non-last block: 16th word accepted at cycle k; next at k+1 at the earliest; in_ready returns at k+2.
- Final block: next follows the last accepted word after (14 − widx_after_last) PAD/zero cycles plus 2 LEN cycles, then ISSUE.
- `next`, `first_block` and `msg_done` are registered-state decodes and hold for exactly one cycle.
- core_ready low in ISSUE stalls indefinitely; `block` is held stable while stalled.
- core_ready is combinational from the core. It is sampled only in ISSUE, so there is no loop.

## Configuration
- `SHA256_PAD_BLKCNT_EN`: defined adds output `blk_count` (32 bits, reset 0). It increments on every `next` pulse and wraps at 2^32.
- Undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- `sha256_pkg` holds:
  - the state enum typedef;
  - constants BLOCK_WORDS=16, LEN_WORD_IDX=14, PAD_BYTE=8'h80;
  - a pure function `pad_last_word(data, nbytes)` returning the masked word with 0x80 inserted.
- No sub-module; the buffer, counter and FSM live in one module.

## Test plan
- "abc": one word 0x61626300, in_last, in_bytes=3, core_ready=1. Expect one next, 16 cycles after accept, with first_block=1 and msg_done=1. Block: word0=0x61626380, words1..14=0, word15=0x00000018.
- Empty message: in_data=0, in_last, in_bytes=0. Expect word0=0x80000000, words1..15=0, one next with first_block=msg_done=1.
- 55 bytes (13 full words plus 3 bytes): expect a single block with word13=xxxxxx80 and word15=0x000001B8.
- 56 bytes (14 full words, last in_bytes=4): expect two nexts.
  - Block 1: word14=0x80000000, word15=0, first_block=1, msg_done=0.
  - Block 2: words0..13=0, word15=0x000001C0, msg_done=1.
- 64-byte message with core_ready held low for 70 cycles after the first next: block 2 is not issued until core_ready rises. in_ready=0 and block is stable while stalled.
- Assert rst after the 9th word of a message, then send "abc". Expect only the "abc" block, with bitlen 0x18 and first_block=1. With `SHA256_PAD_BLKCNT_EN`, blk_count=1.
